lsu_bus_master: RTL
===================

# lsu_bus_master

Load/store unit initiator that sits between the execute stage and the data-memory responder. It accepts one load or store per transaction and converts byte/half/word accesses into word-aligned bus requests with byte masks. It completes a valid/ready request/response exchange with memory, then extracts and extends the load data. Each access is retired to write-back through its own valid/ready handshake.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, bus data width (fixed at 32; 4 byte lanes)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset (sampled on posedge clk)
- req_valid  in  1  execute stage offers an access
- req_ready  out  1  block can accept (high only in IDLE)
- req_wen  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  0=byte, 1=half, 2=word, 3 treated as word
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_rd  in  5  destination register
- mem_valid  out  1  bus request valid
- mem_ready  in  1  responder accepts request
- mem_addr  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wen, mem_wdata[32], mem_wmask[4]  out  store controls, lane-shifted
- mem_rvalid  in  1  response valid (load data, or store ack)
- mem_rready  out  1  block can take response
- mem_rdata  in  32  raw word from memory
- wb_valid  out  1  access retired
- wb_ready  in  1  write-back accepts
- wb_wen  out  1  register write required (load, no fault)
- wb_rd  out  5  destination register
- wb_rdata  out  32  extended load data; 0 for stores
- wb_fault  out  1  misaligned access (0 when feature compiled out)

## Operation
- States: IDLE, REQ, RESP, WB.
- IDLE: req_ready=1. On req_valid, capture all req_* fields and go to REQ. With misalign check enabled and access misaligned, go to WB with wb_fault=1 instead.
- REQ: mem_valid=1, address/controls stable. On mem_ready, go to RESP.
- RESP: mem_rready=1. On mem_rvalid, register extended data and go to WB.
- WB: wb_valid=1 until wb_ready, then IDLE.
- off=addr[1:0]. Mask is byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111. The mask is truncated to 4 bits and upper lanes are dropped.
- mem_wdata = req_wdata << (8*off), truncated to 32 bits.
- Load: sh = mem_rdata >> (8*off). Byte takes sh[7:0] and half takes sh[15:0], sign-extended unless req_unsigned.
- Misaligned: half with off[0]=1, or word with off!=0.
- Stores still wait for mem_rvalid (write ack); mem_rdata is ignored.

## Timing
- Reset: state=IDLE. req_ready=1. mem_valid, mem_wen, mem_rready, wb_valid, wb_wen, wb_fault=0. mem_addr, mem_wdata, mem_wmask, wb_rd, wb_rdata=0.
- Accept in cycle 0; mem_valid asserts in cycle 1.
- Minimum latency: mem_ready in cycle 1 and mem_rvalid in cycle 2 give wb_valid in cycle 3.
- mem_rvalid is sampled only in RESP. A response coincident with the request handshake is a responder protocol violation and is ignored.
- All outputs are registered or decoded from state only; there are no input-to-output combinational paths.
- rst_n low in any state returns to IDLE next edge. The outstanding transaction is dropped, and the responder is reset by the same rst_n.
- One outstanding transaction maximum; no new request is accepted until WB completes.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned accesses issue no bus transaction and retire one cycle after acceptance with wb_fault=1 and wb_wen=0.
- LSU_MISALIGN_CHECK_EN undefined: no check is made; misaligned accesses use truncated masks and shifts as above; wb_fault is tied 0.

## Structure
- Package lsu_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W)
  - state enum (S_IDLE, S_REQ, S_RESP, S_WB)
  - lane-count constant 4
- Sub-module lsu_align (combinational):
  - inputs: size, off, wdata, rdata, unsigned
  - outputs: wmask, shifted wdata, extended rdata, misaligned flag
- The top level holds the FSM and capture registers.

## Test plan
- Store byte, addr 0x80000003, wdata 0x000000AB -> mem_addr 0x80000000, mem_wmask 4'b1000, mem_wdata 0xAB000000, mem_wen=1; after ack, wb_valid=1 and wb_wen=0.
- Load byte, addr 0x80000002, mem_rdata 0x12F45678:
  - signed -> wb_rdata 0xFFFFFFF4
  - unsigned -> 0x000000F4
  - lhu at 0x80000002 -> 0x000012F4
- Backpressure: mem_ready low for 3 cycles -> mem_valid and mem_addr/wdata/wmask held stable. With wb_ready low for 2 cycles, wb_valid, wb_rdata and wb_rd are held and req_ready=0.
- Misaligned word load at 0x80000001:
  - with LSU_MISALIGN_CHECK_EN -> mem_valid never asserted; wb_valid asserts the cycle after acceptance with wb_fault=1 and wb_wen=0
  - without the macro -> mem_addr 0x80000000 and mem_wmask 4'b1111 are issued
- Reset in RESP: drive rst_n=0 for one cycle -> next cycle state IDLE, req_ready=1, mem_rready=0, wb_valid=0. A subsequent load completes normally.
- Back-to-back loads with zero-wait responder -> each retires in 4 cycles with correct wb_rd ordering.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and lane count
// shared by the load/store bus master and its aligner.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_WB
    } state_t;

endpackage

// File: rtl/lsu_bus_master_align.sv
// lsu_align: byte-lane steering for stores and
// shift/extend of load data; flags misaligned accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       off,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    input  logic             is_unsigned,
    output logic [LANES-1:0] wmask,
    output logic [31:0]      wdata_sh,
    output logic [31:0]      rdata_ext,
    output logic             misaligned
);

    logic [31:0] sh;
    logic        is_b;
    logic        is_h;

    assign is_b = (size == SZ_B);
    assign is_h = (size == SZ_H);

    assign wdata_sh = wdata << {off, 3'b000};
    assign sh       = rdata >> {off, 3'b000};

    // size 3 falls through to word behaviour
    assign misaligned = (is_h & off[0])
                      | (~is_b & ~is_h & (off != 2'd0));

    always_comb begin
        wmask     = 4'b1111;
        rdata_ext = sh;
        unique case (1'b1)
            is_b: begin
                wmask     = 4'b0001 << off;
                rdata_ext = {{24{sh[7] & ~is_unsigned}}, sh[7:0]};
            end
            is_h: begin
                wmask     = 4'b0011 << off;
                rdata_ext = {{16{sh[15] & ~is_unsigned}}, sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: one-outstanding load/store initiator.
// Define LSU_MISALIGN_CHECK_EN to retire misaligned accesses as faults.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [4:0]            req_rd,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_wen,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_rdata,
    output logic                  wb_fault
);

    state_t     state;
    logic [1:0] size_q;
    logic [1:0] off_q;
    logic       uns_q;

    logic [1:0]       size_sel;
    logic [1:0]       off_sel;
    logic [LANES-1:0] wmask;
    logic [31:0]      wdata_sh;
    logic [31:0]      rdata_ext;
    logic             misaligned;
    logic             fault_hit;

    // request fields steer the aligner in IDLE, captured ones afterwards
    assign size_sel = (state == S_IDLE) ? req_size : size_q;
    assign off_sel  = (state == S_IDLE) ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .size        (size_sel),
        .off         (off_sel),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .is_unsigned (uns_q),
        .wmask       (wmask),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign fault_hit = misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_fault <= 1'b0;
        end else if (state == S_IDLE && req_valid) begin
            wb_fault <= misaligned;
        end else if (state == S_WB && wb_ready) begin
            wb_fault <= 1'b0;
        end
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign fault_hit         = 1'b0;
    assign wb_fault          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_rready <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            wb_valid   <= 1'b0;
            wb_wen     <= 1'b0;
            wb_rd      <= '0;
            wb_rdata   <= '0;
            size_q     <= SZ_B;
            off_q      <= '0;
            uns_q      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wen   <= req_wen;
                    mem_wdata <= wdata_sh;
                    mem_wmask <= wmask;
                    wb_rd     <= req_rd;
                    size_q    <= req_size;
                    off_q     <= req_addr[1:0];
                    uns_q     <= req_unsigned;
                    if (fault_hit) begin
                        state    <= S_WB;
                        wb_valid <= 1'b1;
                        wb_wen   <= 1'b0;
                        wb_rdata <= '0;
                    end else begin
                        state     <= S_REQ;
                        mem_valid <= 1'b1;
                    end
                end
                S_REQ: if (mem_ready) begin
                    state      <= S_RESP;
                    mem_valid  <= 1'b0;
                    mem_rready <= 1'b1;
                end
                // store acks carry no data; write-back gets zero
                S_RESP: if (mem_rvalid) begin
                    state      <= S_WB;
                    mem_rready <= 1'b0;
                    wb_valid   <= 1'b1;
                    wb_wen     <= ~mem_wen;
                    wb_rdata   <= mem_wen ? '0 : rdata_ext;
                end
                S_WB: if (wb_ready) begin
                    state     <= S_IDLE;
                    wb_valid  <= 1'b0;
                    wb_wen    <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
